// File: rtl/seq_pkg.sv
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and widths for the serial start-pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam int PAT_W    = 4;
    localparam int BYTE_W   = 8;
    localparam int BITCNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/seq_shreg.sv
// ============================================================================
// Module      : seq_shreg
// Description : Left-shifting shift register (new bit enters at the LSB) with
//               shift enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_next = i_din;
        end else begin : g_multi
            assign w_next = {r_q[WIDTH-2:0], i_din};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector.sv
// ============================================================================
// Module      : seq_detector
// Description : Hunts a serial stream for a 4-bit start pattern, captures the
//               following byte MSB-first and offers it on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector
    import seq_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [BYTE_W-1:0] byte_out,
    output logic             byte_vld,
    input  logic             byte_rdy,
    output logic             overrun
);

    localparam int                   c_FILL_W   = $clog2(PAT_W);
    localparam logic [c_FILL_W-1:0]  c_FILL_MAX = c_FILL_W'(PAT_W - 1);
    localparam logic [c_FILL_W-1:0]  c_FILL_ONE = c_FILL_W'(1);
    localparam logic [BITCNT_W-1:0]  c_LAST_BIT = BITCNT_W'(BYTE_W - 1);
    localparam logic [BITCNT_W-1:0]  c_BIT_ONE  = BITCNT_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE  = CNT_W'(1);

    state_t                r_state;
    logic [c_FILL_W-1:0]   r_fill;
    logic [BITCNT_W-1:0]   r_bitcnt;
    logic                  r_match;
    logic [CNT_W-1:0]      r_match_cnt;
    logic [BYTE_W-1:0]     r_byte_out;
    logic                  r_byte_vld;
    logic                  r_overrun;

    logic [PAT_W-2:0]      w_hist;
    logic [BYTE_W-1:0]     w_cap;
    logic                  w_hunt_bit;
    logic                  w_cap_bit;
    logic                  w_match;
    logic                  w_byte_done;
    logic                  w_xfer;
    logic [BYTE_W-1:0]     w_new_byte;
    logic                  w_unused_cap_msb;

    // clr gates both shift enables so it wins over a same-cycle valid bit
    assign w_hunt_bit  = (r_state == HUNT) && bit_vld && !clr;
    assign w_cap_bit   = (r_state == CAPTURE) && bit_vld && !clr;
    assign w_match     = w_hunt_bit && (r_fill == c_FILL_MAX) && ({w_hist, bit_in} == PATTERN);
    assign w_byte_done = w_cap_bit && (r_bitcnt == c_LAST_BIT);
    assign w_xfer      = r_byte_vld && byte_rdy;

    // The 8th bit is still on bit_in when the byte completes
    assign w_new_byte       = {w_cap[BYTE_W-2:0], bit_in};
    assign w_unused_cap_msb = w_cap[BYTE_W-1];

    seq_shreg #(
        .WIDTH (PAT_W - 1)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr || w_match),
        .i_shift (w_hunt_bit),
        .i_din   (bit_in),
        .o_q     (w_hist)
    );

    seq_shreg #(
        .WIDTH (BYTE_W)
    ) u_capture (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr || w_match),
        .i_shift (w_cap_bit),
        .i_din   (bit_in),
        .o_q     (w_cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_fill      <= '0;
            r_bitcnt    <= '0;
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_byte_out  <= '0;
            r_byte_vld  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clr) begin
            r_state     <= HUNT;
            r_fill      <= '0;
            r_bitcnt    <= '0;
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_byte_vld  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_match <= w_match;

            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        r_state  <= CAPTURE;
                        r_fill   <= '0;
                        r_bitcnt <= '0;
                        if (r_match_cnt != '1) begin
                            r_match_cnt <= r_match_cnt + c_CNT_ONE;
                        end
                    end else if (bit_vld && (r_fill != c_FILL_MAX)) begin
                        r_fill <= r_fill + c_FILL_ONE;
                    end
                end
                CAPTURE: begin
                    if (bit_vld) begin
                        r_bitcnt <= r_bitcnt + c_BIT_ONE;
                        if (w_byte_done) begin
                            r_state <= HUNT;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase

            // A completing byte overrides the transfer clear; only a byte
            // that is left untaken on this edge counts as overwritten.
            if (w_byte_done) begin
                r_byte_out <= w_new_byte;
                r_byte_vld <= 1'b1;
                if (r_byte_vld && !byte_rdy) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_byte_vld <= 1'b0;
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_match_cnt;
    assign byte_out  = r_byte_out;
    assign byte_vld  = r_byte_vld;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire
